// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter. Enables the oscillator and synchronises
// its output into clk. After a settle period it counts rising edges over a
// programmable window, then holds the result for a controller to collect.
//
// Handshake: start is accepted only in IDLE, on the edge where it is high.
// busy rises on that edge. valid stays high with count/overflow frozen until
// ack is seen high on an edge. On that edge valid and busy fall and the block
// returns to IDLE. If start is high on that same edge, it is ignored.
module ro_freq_meter #(
  parameter int CNT_W         = 16,
  parameter int GATE_W        = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic              ro_in,
  output logic              ro_en,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              ack,
  output logic [1:0]        state_dbg   // current FSM state, for observation
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // The timer is shared by SETTLE and MEASURE, so it is sized for the longer of the two.
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (GATE_W > SW) ? GATE_W : SW;

  state_t              state_q;
  state_t              state_d;
  logic [TW-1:0]       timer_q;
  logic [GATE_W-1:0]   gate_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                sync_prev_q;
  logic                rise;
  logic                settle_last;
  logic                gate_last;
  logic [GATE_W-1:0]   gate_m1;

  // Bring the asynchronous oscillator output into clk through a plain flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ro_in};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // A rising edge is a synchronised 1 whose previous sample was 0. Every state
  // runs this detector, so an edge seen in the first MEASURE cycle is counted.
  assign rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  // Terminal-cycle decodes for the two timed states.
  assign gate_m1     = gate_q - 1'b1;
  assign settle_last = (timer_q == TW'(SETTLE_CYCLES - 1));
  assign gate_last   = (timer_q == TW'(gate_m1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. Each timed state moves on after its last cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)       state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = MEASURE;
      MEASURE: if (gate_last)   state_d = DONE;
      DONE:    if (ack)         state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // The timer counts cycles within a state and clears whenever the state changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (state_d != state_q) begin
      timer_q <= '0;
    end else if (state_q == SETTLE || state_q == MEASURE) begin
      timer_q <= timer_q + 1'b1;
    end
  end

  // Capture the window length on an accepted start. A length of 0 is treated as 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gate_q <= '0;
    end else if (state_q == IDLE && start) begin
      gate_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
    end
  end

  // Edge counter. It clears on start and counts only in MEASURE.
  // It saturates at all-ones; overflow records that an edge was lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (state_q == IDLE && start) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (state_q == MEASURE && rise) begin
      if (count == {CNT_W{1'b1}}) overflow <= 1'b1;
      else                        count    <= count + 1'b1;
    end
  end

  // All control outputs decode from the state register. They drop as soon as reset asserts.
  assign ro_en     = (state_q == SETTLE) || (state_q == MEASURE);
  assign busy      = (state_q != IDLE);
  assign valid     = (state_q == DONE);
  assign state_dbg = state_q;

  // The oscillator is never left running while a result is being presented.
  a_valid_no_ro: assert property (@(posedge clk) disable iff (!rst) valid |-> !ro_en);

endmodule
